uart_rx_oversampled: RTL and testbench

Parametrised UART receiver with an input synchroniser, 3-sample majority voting at mid-bit, start-bit glitch rejection, configurable stop bits and per-frame error reporting. It sits between the asynchronous serial pin and a receive FIFO, using the FIFO's `full` / `we` write interface. Optional parity checking is compiled in by macro.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 56 +++++
 rtl/uart_rx_oversampled.sv | 154 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WRITE,
      BREAK
   } rx_state_t;

   // The three votes are taken at mid-1, mid and mid+1 of each bit.
   localparam int unsigned SAMPLE_LEAD = 1;
   localparam int unsigned SAMPLE_LAG  = 1;

   function automatic int unsigned clocks_per_bit(input int unsigned freq, input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit clock counter and 3-sample majority vote.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned CPB         = 868,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic hold,
   output logic s,
   output logic mid,
   output logic bit_val,
   output logic bit_end
);

   localparam int unsigned CNT_W = $clog2(CPB);
   localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(CPB / 2 - SAMPLE_LEAD);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(CPB / 2);
   localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(CPB / 2 + SAMPLE_LAG);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

   logic [SYNC_STAGES-1:0] sync_p;
   logic [CNT_W-1:0]       cnt;
   logic                   samp_p0;
   logic                   samp_p1;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) sync_p <= '1;
      else     sync_p <= {sync_p[SYNC_STAGES-2:0], din};
   end

   assign s = sync_p[SYNC_STAGES-1];

   // Held at zero while idle so that count 0 is the first cycle of the start bit.
   always_ff @(posedge clk) begin
      if (rst || hold)           cnt <= '0;
      else if (cnt == CNT_LAST)  cnt <= '0;
      else                       cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (cnt == CNT_S0) samp_p0 <= s;
      if (cnt == CNT_S1) samp_p1 <= s;
   end

   assign mid     = (cnt == CNT_S2);
   assign bit_end = (cnt == CNT_LAST);
   assign bit_val = majority3(samp_p0, samp_p1, s);

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver with majority-voted sampling, glitch rejection and per-frame errors.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
   parameter int unsigned BAUD_RATE       = 32'd115200,
   parameter int unsigned WORD_WIDTH      = 32'd8,
   parameter int unsigned STOP_BITS       = 32'd1,
   parameter bit          PARITY_ODD      = 1'b0,
   parameter int unsigned SYNC_STAGES     = 32'd2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din,
   output logic [WORD_WIDTH-1:0] dout,
   input  logic                  full,
   output logic                  we,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  parity_err,
   output logic                  busy
);

   localparam int unsigned CPB       = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
   localparam logic [3:0]  LAST_BIT  = 4'(WORD_WIDTH - 1);
   localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

   if (CPB < 4 || WORD_WIDTH < 5 || WORD_WIDTH > 9 || STOP_BITS < 1 || STOP_BITS > 2
       || SYNC_STAGES < 2) begin : g_bad_params
      $error("uart_rx_oversampled: illegal parameter combination");
   end

   rx_state_t             state;
   logic [3:0]            bit_idx;
   logic                  stop_idx;
   logic [WORD_WIDTH-1:0] shift_reg;
   logic                  s;
   logic                  mid;
   logic                  bit_val;
   logic                  bit_end;
   logic                  par_bad;

   uart_rx_sampler #(
      .CPB         (CPB),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .hold    (state == IDLE),
      .s       (s),
      .mid     (mid),
      .bit_val (bit_val),
      .bit_end (bit_end)
   );

   assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
   logic parity_err_r;
   assign parity_err = parity_err_r;
`else
   assign parity_err = 1'b0;
   assign par_bad    = 1'b0;
   // PARITY_ODD has no effect when no parity bit is carried.
   if (PARITY_ODD) begin : g_parity_unused
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         dout        <= '0;
         we          <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_r <= 1'b0;
         par_bad      <= 1'b0;
`endif
      end else begin
         we          <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_r <= 1'b0;
`endif
         case (state)
            IDLE: if (!s) state <= START;
            START: begin
               if (mid && bit_val) begin
                  state <= IDLE;
               end else if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (mid) shift_reg <= {bit_val, shift_reg[WORD_WIDTH-1:1]};
               if (bit_end) begin
                  if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                     stop_idx <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (mid) par_bad <= ((^shift_reg) ^ PARITY_ODD) != bit_val;
               if (bit_end) state <= STOP;
            end
`endif
            // Leave at the mid-sample of the last stop bit so a following start edge is not missed.
            STOP: begin
               if (mid) begin
                  if (!bit_val) begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end else if (stop_idx == LAST_STOP) begin
                     state <= WRITE;
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end
            end
            WRITE: begin
               if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                  parity_err_r <= 1'b1;
`endif
               end else if (full) begin
                  overrun_err <= 1'b1;
               end else begin
                  we   <= 1'b1;
                  dout <= shift_reg;
               end
               state <= IDLE;
            end
            BREAK: if (s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at 100 MHz / 115200 baud, 8 data bits, 2 stop bits.
module tb_uart_rx_oversampled;

   localparam int unsigned CPB = 868;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b1;
   logic       full = 1'b0;
   logic [7:0] dout;
   logic       we;
   logic       frame_err;
   logic       overrun_err;
   logic       parity_err;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int n_we = 0, n_fe = 0, n_oe = 0, n_pe = 0;
   logic [7:0] we_data = 8'h00;
   int we0, fe0, oe0, pe0;

`ifdef UART_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_rx_oversampled #(
      .CLOCK_FREQUENCY (32'd100_000_000),
      .BAUD_RATE       (32'd115200),
      .WORD_WIDTH      (32'd8),
      .STOP_BITS       (32'd2),
      .PARITY_ODD      (1'b0),
      .SYNC_STAGES     (32'd2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .dout        (dout),
      .full        (full),
      .we          (we),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err),
      .busy        (busy)
   );

   // Pulse counters: a strobe held for two cycles counts twice.
   always @(negedge clk) begin
      if (we) begin
         n_we++;
         we_data = dout;
      end
      if (frame_err)   n_fe++;
      if (overrun_err) n_oe++;
      if (parity_err)  n_pe++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      we0 = n_we; fe0 = n_fe; oe0 = n_oe; pe0 = n_pe;
   endtask

   task automatic drive_bit(input logic b);
      din = b;
      wait_cycles(CPB);
   endtask

   task automatic send_head(input logic [7:0] data);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^data) ^ par_flip);
`endif
   endtask

   task automatic send_frame(input logic [7:0] data);
      send_head(data);
      drive_bit(1'b1);
      drive_bit(1'b1);
      wait_cycles(20);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      din = 1'b1;
      wait_cycles(5);
      n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
      n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
      n_tests++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_errs: got %b want 000", {frame_err, overrun_err, parity_err}); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      wait_cycles(10);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic_rx();
      snap();
      send_frame(8'hA5);
      n_tests++; if (n_we - we0 != 1) begin n_fail++; $display("FAIL basic_we_count: got %0d want 1", n_we - we0); end
      n_tests++; if (we_data !== 8'hA5) begin n_fail++; $display("FAIL basic_we_data: got %h want a5", we_data); end
      n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h want a5", dout); end
      n_tests++; if ((n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0) != 0) begin
         n_fail++; $display("FAIL basic_errs: got %0d error pulses want 0", (n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0)); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
   endtask

   task automatic test_frame_error();
      snap();
      send_head(8'h3C);
      din = 1'b0;
      wait_cycles(10 * CPB);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b want 1", busy); end
      n_tests++; if (n_fe - fe0 != 1) begin n_fail++; $display("FAIL frame_err_count: got %0d want 1", n_fe - fe0); end
      n_tests++; if (n_we - we0 != 0) begin n_fail++; $display("FAIL frame_no_we: got %0d want 0", n_we - we0); end
      din = 1'b1;
      wait_cycles(20);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release_busy: got %b want 1'b0", busy); end
      n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL frame_dout_hold: got %h want a5", dout); end
      send_frame(8'h11);
      n_tests++; if (n_we - we0 != 1) begin n_fail++; $display("FAIL after_break_we: got %0d want 1", n_we - we0); end
      n_tests++; if (dout !== 8'h11) begin n_fail++; $display("FAIL after_break_dout: got %h want 11", dout); end
      n_tests++; if (n_fe - fe0 != 1) begin n_fail++; $display("FAIL after_break_fe: got %0d want 1", n_fe - fe0); end
   endtask

   task automatic test_overrun();
      snap();
      full = 1'b1;
      send_frame(8'h55);
      full = 1'b0;
      n_tests++; if (n_oe - oe0 != 1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", n_oe - oe0); end
      n_tests++; if (n_we - we0 != 0) begin n_fail++; $display("FAIL overrun_no_we: got %0d want 0", n_we - we0); end
      n_tests++; if (dout !== 8'h11) begin n_fail++; $display("FAIL overrun_dout: got %h want 11", dout); end
      n_tests++; if (n_fe - fe0 != 0) begin n_fail++; $display("FAIL overrun_fe: got %0d want 0", n_fe - fe0); end
   endtask

   task automatic test_glitch();
      int k;
      snap();
      din = 1'b0;
      wait_cycles(1);
      din = 1'b1;
      wait_cycles(500);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch1_busy: got %b want 0", busy); end
      din = 1'b0;
      wait_cycles(10);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch300_start: got %b want 1", busy); end
      wait_cycles(290);
      din = 1'b1;
      k = 0;
      while (busy !== 1'b0 && k < 434) begin
         @(negedge clk);
         k++;
      end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch300_busy: got %b want 0 within 434 cycles", busy); end
      wait_cycles(20);
      n_tests++; if (n_we - we0 != 0) begin n_fail++; $display("FAIL glitch_we: got %0d want 0", n_we - we0); end
      n_tests++; if ((n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0) != 0) begin
         n_fail++; $display("FAIL glitch_errs: got %0d want 0", (n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0)); end
   endtask

   task automatic test_parity();
`ifdef UART_RX_PARITY_EN
      snap();
      par_flip = 1'b1;
      send_frame(8'h07);
      par_flip = 1'b0;
      n_tests++; if (n_pe - pe0 != 1) begin n_fail++; $display("FAIL parity_err_count: got %0d want 1", n_pe - pe0); end
      n_tests++; if (n_we - we0 != 0) begin n_fail++; $display("FAIL parity_no_we: got %0d want 0", n_we - we0); end
      send_frame(8'h07);
      n_tests++; if (n_we - we0 != 1) begin n_fail++; $display("FAIL parity_good_we: got %0d want 1", n_we - we0); end
      n_tests++; if (dout !== 8'h07) begin n_fail++; $display("FAIL parity_good_dout: got %h want 07", dout); end
      n_tests++; if (n_pe - pe0 != 1) begin n_fail++; $display("FAIL parity_good_pe: got %0d want 1", n_pe - pe0); end
`else
      n_tests++; if (n_pe != 0) begin n_fail++; $display("FAIL parity_tied: got %0d pulses want 0", n_pe); end
`endif
   endtask

   task automatic test_reset_abort();
      snap();
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b0);
      wait_cycles(CPB / 2);
      rst = 1'b1;
      din = 1'b1;
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(100);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL abort_dout: got %h want 00", dout); end
      n_tests++; if ((n_we - we0) + (n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0) != 0) begin
         n_fail++; $display("FAIL abort_pulses: got %0d want 0", (n_we - we0) + (n_fe - fe0) + (n_oe - oe0) + (n_pe - pe0)); end
      send_frame(8'h81);
      n_tests++; if (n_we - we0 != 1) begin n_fail++; $display("FAIL two_stop_we: got %0d want 1", n_we - we0); end
      n_tests++; if (dout !== 8'h81) begin n_fail++; $display("FAIL two_stop_dout: got %h want 81", dout); end
      n_tests++; if (n_fe - fe0 != 0) begin n_fail++; $display("FAIL two_stop_fe: got %0d want 0", n_fe - fe0); end
   endtask

   initial begin
      test_reset();
      test_basic_rx();
      test_frame_error();
      test_overrun();
      test_glitch();
      test_parity();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
